maxpool_2x2_stride2: RTL and testbench

Downstream stage of the 2x2 line buffer. It consumes the vertically aligned pixel pair stream (upper row, lower row) plus its valid flag. It performs 2x2, stride-2 max pooling on signed feature-map data and emits one pooled value per window, tagged with output row and column indices. It feeds the next conv/sparse stage at a quarter of the input pixel rate.

---
 rtl/maxpool_2x2_stride2_pkg.sv | 14 +
 rtl/maxpool_2x2_stride2_max2_signed.sv | 12 +
 rtl/maxpool_2x2_stride2.sv | 112 +++++++++++
 tb/tb_maxpool_2x2_stride2.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_2x2_stride2_pkg.sv
// Shared constants for the 2x2 stride-2 max-pooling stage.
// A future pool-mode encoding (max/avg) belongs here as well.
package maxpool_2x2_stride2_pkg;

  localparam int DEF_DATA_COL_NUM = 28;
  localparam int DEF_WORDLENGTH   = 16;
  localparam int DEF_COL_LENGTH   = 5;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxpool_2x2_stride2_max2_signed.sv
// Combinational two's-complement maximum of two operands.
module max2_signed #(
  parameter int WORDLENGTH = 16
) (
  input  logic signed [WORDLENGTH-1:0] a_i,
  input  logic signed [WORDLENGTH-1:0] b_i,
  output logic signed [WORDLENGTH-1:0] max_o
);

  assign max_o = (a_i >= b_i) ? a_i : b_i;

endmodule

// File: rtl/maxpool_2x2_stride2.sv
// 2x2 stride-2 signed max pooling over a vertically aligned pixel-pair stream.
// Even columns park the column max in hold; odd columns of even row pairs emit a window.
module maxpool_2x2_stride2
  import maxpool_2x2_stride2_pkg::*;
#(
  parameter int DATA_COL_NUM = DEF_DATA_COL_NUM,
  parameter int WORDLENGTH   = DEF_WORDLENGTH,
  parameter int COL_LENGTH   = DEF_COL_LENGTH
) (
  input  logic                         clk,
  input  logic                         irst,
  input  logic                         in_valid,
  input  logic signed [WORDLENGTH-1:0] pixel_top,
  input  logic signed [WORDLENGTH-1:0] pixel_bot,
  output logic signed [WORDLENGTH-1:0] pool_out,
  output logic                         out_valid,
  output logic        [COL_LENGTH-1:0] out_row,
  output logic        [COL_LENGTH-1:0] out_col,
  output logic                         frame_done
);

  localparam int CW = cnt_w(DATA_COL_NUM);
  localparam logic [CW-1:0] LAST_COL = CW'(DATA_COL_NUM - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(DATA_COL_NUM - 2);

  logic [CW-1:0]                col_cnt_q, col_cnt_d;
  logic [CW-1:0]                row_cnt_q, row_cnt_d;
  logic signed [WORDLENGTH-1:0] hold_q, hold_d;
  logic signed [WORDLENGTH-1:0] pool_q, pool_d;
  logic                         valid_q, valid_d;
  logic                         done_q, done_d;
  logic [COL_LENGTH-1:0]        row_q, row_d;
  logic [COL_LENGTH-1:0]        col_q, col_d;
  logic signed [WORDLENGTH-1:0] colmax;
  logic signed [WORDLENGTH-1:0] winmax;

  max2_signed #(.WORDLENGTH(WORDLENGTH)) u_colmax (
    .a_i   (pixel_top),
    .b_i   (pixel_bot),
    .max_o (colmax)
  );

  max2_signed #(.WORDLENGTH(WORDLENGTH)) u_winmax (
    .a_i   (hold_q),
    .b_i   (colmax),
    .max_o (winmax)
  );

  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    hold_d    = hold_q;
    pool_d    = pool_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    row_d     = row_q;
    col_d     = col_q;

    // A gap in the stream means upstream restarted its frame; drop any partial window.
    if (!in_valid) begin
      col_cnt_d = '0;
      row_cnt_d = '0;
      hold_d    = '0;
    end else begin
      if (col_cnt_q == LAST_COL) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end

      if (!col_cnt_q[0]) begin
        hold_d = colmax;
      end else if (!row_cnt_q[0]) begin
        pool_d  = winmax;
        valid_d = 1'b1;
        row_d   = COL_LENGTH'(row_cnt_q >> 1);
        col_d   = COL_LENGTH'(col_cnt_q >> 1);
        done_d  = (row_cnt_q == LAST_ROW) && (col_cnt_q == LAST_COL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (irst) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      hold_q    <= '0;
      pool_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      hold_q    <= hold_d;
      pool_q    <= pool_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

  assign pool_out   = pool_q;
  assign out_valid  = valid_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_maxpool_2x2_stride2.sv
// Bench for maxpool_2x2_stride2: a 4x4 instance for directed tables and corner
// sequences, and a 28x28 instance for random frames against an image-level model.
module tb_maxpool_2x2_stride2;

  localparam int WL = 16;
  localparam int CL = 5;
  localparam int NS = 4;
  localparam int NL = 28;
  localparam int M  = -32768;
  localparam int P  = 32767;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic irst;

  logic                 s_vld;
  logic signed [WL-1:0] s_top, s_bot, s_pool;
  logic                 s_ov, s_done;
  logic [CL-1:0]        s_row, s_col;

  logic                 l_vld;
  logic signed [WL-1:0] l_top, l_bot, l_pool;
  logic                 l_ov, l_done;
  logic [CL-1:0]        l_row, l_col;

  maxpool_2x2_stride2 #(.DATA_COL_NUM(NS), .WORDLENGTH(WL), .COL_LENGTH(CL)) dut_s (
    .clk        (clk),
    .irst       (irst),
    .in_valid   (s_vld),
    .pixel_top  (s_top),
    .pixel_bot  (s_bot),
    .pool_out   (s_pool),
    .out_valid  (s_ov),
    .out_row    (s_row),
    .out_col    (s_col),
    .frame_done (s_done)
  );

  maxpool_2x2_stride2 #(.DATA_COL_NUM(NL), .WORDLENGTH(WL), .COL_LENGTH(CL)) dut_l (
    .clk        (clk),
    .irst       (irst),
    .in_valid   (l_vld),
    .pixel_top  (l_top),
    .pixel_bot  (l_bot),
    .pool_out   (l_pool),
    .out_valid  (l_ov),
    .out_row    (l_row),
    .out_col    (l_col),
    .frame_done (l_done)
  );

  typedef struct {
    logic vld;
    int   top;
    int   bot;
    logic ev;
    int   pool;
    int   row;
    int   col;
    logic done;
  } vec_t;

  typedef struct {
    int   pool;
    int   row;
    int   col;
    logic done;
  } win_t;

  vec_t vecs[$];
  win_t sq[$];
  win_t lq[$];
  win_t exp_l[$];
  int   checks = 0;
  int   errors = 0;
  int   l_done_cnt = 0;
  int   stray_done = 0;
  int   img[NL][NL];

  always @(negedge clk) begin
    if (s_ov) sq.push_back('{int'(s_pool), int'(s_row), int'(s_col), s_done});
    if (l_ov) lq.push_back('{int'(l_pool), int'(l_row), int'(l_col), l_done});
    if (l_done) l_done_cnt++;
    if ((s_done && !s_ov) || (l_done && !l_ov)) stray_done++;
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic add(input logic v, input int t, input int b, input logic ev,
                     input int p, input int r, input int c, input logic d);
    vecs.push_back('{v, t, b, ev, p, r, c, d});
  endtask

  task automatic sbeat(input int t, input int b);
    @(negedge clk);
    s_vld = 1'b1;
    s_top = WL'(t);
    s_bot = WL'(b);
  endtask

  task automatic sidle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_vld = 1'b0;
      s_top = '0;
      s_bot = '0;
    end
  endtask

  task automatic expect_s(input string nm, input int p, input int r, input int c, input logic d);
    win_t w;
    if (sq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual no_window required pool %0d at (%0d,%0d)", nm, p, r, c);
    end else begin
      w = sq.pop_front();
      chk({nm, "_pool"}, w.pool, p);
      chk({nm, "_row"}, w.row, r);
      chk({nm, "_col"}, w.col, c);
      chk({nm, "_done"}, int'(w.done), int'(d));
    end
  endtask

  task automatic ramp_s(input int nbeats);
    for (int k = 0; k < nbeats; k++) sbeat(k, k + 4);
  endtask

  task automatic expect_full_ramp(input string nm);
    expect_s({nm, "_w00"}, 5, 0, 0, 1'b0);
    expect_s({nm, "_w01"}, 7, 0, 1, 1'b0);
    expect_s({nm, "_w10"}, 13, 1, 0, 1'b0);
    expect_s({nm, "_w11"}, 15, 1, 1, 1'b1);
  endtask

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  initial begin
    irst  = 1'b1;
    s_vld = 1'b0; s_top = '0; s_bot = '0;
    l_vld = 1'b0; l_top = '0; l_bot = '0;

    // Ramp: top = k, bot = k+4; signed window; all-equal tie frame.
    add(1, 0, 4,    0, 0, 0, 0, 0);
    add(1, 1, 5,    1, 5, 0, 0, 0);
    add(1, 2, 6,    0, 5, 0, 0, 0);
    add(1, 3, 7,    1, 7, 0, 1, 0);
    add(1, 4, 8,    0, 7, 0, 1, 0);
    add(1, 5, 9,    0, 7, 0, 1, 0);
    add(1, 6, 10,   0, 7, 0, 1, 0);
    add(1, 7, 11,   0, 7, 0, 1, 0);
    add(1, 8, 12,   0, 7, 0, 1, 0);
    add(1, 9, 13,   1, 13, 1, 0, 0);
    add(1, 10, 14,  0, 13, 1, 0, 0);
    add(1, 11, 15,  1, 15, 1, 1, 1);
    add(0, 0, 0,    0, 15, 1, 1, 0);
    add(1, -5, -7,  0, 15, 1, 1, 0);
    add(1, -3, -100, 1, -3, 0, 0, 0);
    add(1, M, M,    0, -3, 0, 0, 0);
    add(1, M, M,    1, M, 0, 1, 0);
    add(1, -7, M,   0, M, 0, 1, 0);
    add(1, -100, M, 0, M, 0, 1, 0);
    add(1, M, M,    0, M, 0, 1, 0);
    add(1, M, M,    0, M, 0, 1, 0);
    add(1, M, M,    0, M, 0, 1, 0);
    add(1, M, M,    1, M, 1, 0, 0);
    add(1, M, M,    0, M, 1, 0, 0);
    add(1, M, M,    1, M, 1, 1, 1);
    add(0, 0, 0,    0, M, 1, 1, 0);
    add(1, P, P,    0, M, 1, 1, 0);
    add(1, P, P,    1, P, 0, 0, 0);
    add(1, P, P,    0, P, 0, 0, 0);
    add(1, P, P,    1, P, 0, 1, 0);
    for (int k = 4; k < 9; k++) add(1, P, P, 0, P, 0, 1, 0);
    add(1, P, P,    1, P, 1, 0, 0);
    add(1, P, P,    0, P, 1, 0, 0);
    add(1, P, P,    1, P, 1, 1, 1);
    add(0, 0, 0,    0, P, 1, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_valid", int'(s_ov), 0);
    chk("rst_s_pool", int'(s_pool), 0);
    chk("rst_s_row", int'(s_row), 0);
    chk("rst_s_col", int'(s_col), 0);
    chk("rst_s_done", int'(s_done), 0);
    chk("rst_l_valid", int'(l_ov), 0);
    chk("rst_l_pool", int'(l_pool), 0);
    chk("rst_l_done", int'(l_done), 0);
    @(negedge clk);
    irst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      s_vld = vecs[i].vld;
      s_top = WL'(vecs[i].top);
      s_bot = WL'(vecs[i].bot);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), int'(s_ov), int'(vecs[i].ev));
      chk($sformatf("vec%0d_pool", i), int'(s_pool), vecs[i].pool);
      chk($sformatf("vec%0d_row", i), int'(s_row), vecs[i].row);
      chk($sformatf("vec%0d_col", i), int'(s_col), vecs[i].col);
      chk($sformatf("vec%0d_done", i), int'(s_done), int'(vecs[i].done));
    end
    sidle(2);
    sq.delete();

    // Abort: 6 beats, gap of 3, then a complete frame restarting at (0,0).
    ramp_s(6);
    sidle(3);
    ramp_s(12);
    sidle(2);
    expect_s("abort_w00", 5, 0, 0, 1'b0);
    expect_s("abort_w01", 7, 0, 1, 1'b0);
    expect_full_ramp("abort_next");
    chk("abort_extra", sq.size(), 0);
    sq.delete();

    // Reset mid-frame, with in_valid still high during the reset cycle.
    ramp_s(5);
    @(negedge clk);
    irst  = 1'b1;
    s_vld = 1'b1;
    s_top = WL'(5);
    s_bot = WL'(9);
    @(posedge clk);
    #1;
    chk("midrst_valid", int'(s_ov), 0);
    chk("midrst_pool", int'(s_pool), 0);
    chk("midrst_row", int'(s_row), 0);
    chk("midrst_col", int'(s_col), 0);
    chk("midrst_done", int'(s_done), 0);
    @(negedge clk);
    irst  = 1'b0;
    s_vld = 1'b0;
    sidle(1);
    ramp_s(12);
    sidle(2);
    expect_s("midrst_w00", 5, 0, 0, 1'b0);
    expect_s("midrst_w01", 7, 0, 1, 1'b0);
    expect_full_ramp("midrst_next");
    chk("midrst_extra", sq.size(), 0);

    // Full-size random frames checked against window maxima of the image.
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < NL; r++)
        for (int c = 0; c < NL; c++) begin
          case ($urandom_range(0, 15))
            0:       img[r][c] = M;
            1:       img[r][c] = P;
            default: img[r][c] = int'($urandom_range(0, 65535)) - 32768;
          endcase
        end
      exp_l.delete();
      for (int i = 0; i < NL / 2; i++)
        for (int j = 0; j < NL / 2; j++)
          exp_l.push_back('{max4(img[2*i][2*j], img[2*i][2*j+1],
                                 img[2*i+1][2*j], img[2*i+1][2*j+1]),
                            i, j, (i == NL/2 - 1) && (j == NL/2 - 1)});
      lq.delete();
      l_done_cnt = 0;
      for (int k = 0; k < (NL - 1) * NL; k++) begin
        @(negedge clk);
        l_vld = 1'b1;
        l_top = WL'(img[k / NL][k % NL]);
        l_bot = WL'(img[k / NL + 1][k % NL]);
      end
      @(negedge clk);
      l_vld = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("rand%0d_count", f), lq.size(), (NL / 2) * (NL / 2));
      chk($sformatf("rand%0d_done_count", f), l_done_cnt, 1);
      for (int n = 0; n < exp_l.size() && n < lq.size(); n++) begin
        chk($sformatf("rand%0d_w%0d_pool", f, n), lq[n].pool, exp_l[n].pool);
        chk($sformatf("rand%0d_w%0d_row", f, n), lq[n].row, exp_l[n].row);
        chk($sformatf("rand%0d_w%0d_col", f, n), lq[n].col, exp_l[n].col);
        chk($sformatf("rand%0d_w%0d_done", f, n), int'(lq[n].done), int'(exp_l[n].done));
      end
    end

    chk("stray_frame_done", stray_done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
